// File: rtl/wb_byte_fifo_port_if.sv
// Wishbone classic 8-bit slave bus bundle for the byte FIFO port.
interface wb_byte_fifo_port_if;
  logic [31:0] wbs_adr_i;
  logic [7:0]  wbs_dat_i;
  logic        wbs_we_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [2:0]  wbs_cti_i;
  logic [1:0]  wbs_bte_i;
  logic [7:0]  wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        wbs_rty_o;

  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_cti_i, wbs_bte_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );

  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_cti_i, wbs_bte_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );
endinterface

// File: rtl/wb_byte_fifo_port.sv
// Byte mailbox: Wishbone classic slave in front of a TX FIFO and an RX FIFO,
// with DATA / STATUS / CTRL / CLEAR-LEVEL registers and a level interrupt.
// Every beat takes two cycles: request edge -> one-cycle ack or err.
module wb_byte_fifo_port #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_byte_fifo_port_if.slave wb,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_valid_i,
  output logic               rx_ready_o,
  output logic               irq_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  typedef logic [PW-1:0] ptr_t;
  // Pointers of a full FIFO differ only in the wrap bit.
  localparam ptr_t FULL_XOR = ptr_t'(1) << DEPTH_LOG2;

  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  ptr_t       tx_wr, tx_rd, rx_wr, rx_rd;
  ptr_t       rx_count;

  logic       ack_q, err_q, irq_q;
  logic [7:0] dat_q;
  logic [1:0] ctrl_q;
  logic       txerr_q, rxerr_q;

  logic       req;
  logic [1:0] adr;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_push, tx_pop, tx_ovf;
  logic       rx_push, rx_pop, rx_udf;
  logic       flush, clr_err, ctrl_wr;
  logic [7:0] rd_data;

  // Address bits above the byte lane and burst hints carry no meaning here.
  logic unused_bus;
  assign unused_bus = &{1'b0, wb.wbs_adr_i[31:2], wb.wbs_cti_i, wb.wbs_bte_i};

  assign adr = wb.wbs_adr_i[1:0];
  // A beat is only seen once: the registered ack/err masks it on the response edge.
  assign req = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q & ~err_q;

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = ((tx_wr ^ tx_rd) == FULL_XOR);
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = ((rx_wr ^ rx_rd) == FULL_XOR);
  assign rx_count = rx_wr - rx_rd;

  assign tx_data_o  = tx_mem[tx_rd[DEPTH_LOG2-1:0]];
  assign tx_valid_o = ~tx_empty;
  assign rx_ready_o = ~rx_full;

  assign tx_pop  = tx_valid_o & tx_ready_i;
  assign rx_push = rx_valid_i & rx_ready_o;

  assign tx_push = req &  wb.wbs_we_i & (adr == 2'd0) & ~tx_full;
  assign tx_ovf  = req &  wb.wbs_we_i & (adr == 2'd0) &  tx_full;
  assign rx_pop  = req & ~wb.wbs_we_i & (adr == 2'd0) & ~rx_empty;
  assign rx_udf  = req & ~wb.wbs_we_i & (adr == 2'd0) &  rx_empty;
  assign ctrl_wr = req &  wb.wbs_we_i & (adr == 2'd2);
  assign flush   = ctrl_wr & wb.wbs_dat_i[7];
  assign clr_err = req &  wb.wbs_we_i & (adr == 2'd3);

  // Read mux; an empty-RX data read returns zero alongside the error.
  always_comb begin
    rd_data = 8'h00;
    case (adr)
      2'd0: rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd[DEPTH_LOG2-1:0]];
      2'd1: rd_data = {2'b00, rxerr_q, txerr_q, tx_full, tx_empty, rx_full, rx_empty};
      2'd2: rd_data = {6'b0, ctrl_q};
      2'd3: rd_data = 8'(rx_count);
      default: rd_data = 8'h00;
    endcase
  end

  // Bus response, read data capture, CTRL and sticky error flags.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 8'h00;
      ctrl_q  <= 2'b00;
      txerr_q <= 1'b0;
      rxerr_q <= 1'b0;
    end else begin
      ack_q <= req & ~(tx_ovf | rx_udf);
      err_q <= tx_ovf | rx_udf;
      if (req & ~wb.wbs_we_i) dat_q <= rd_data;
      if (ctrl_wr) ctrl_q <= wb.wbs_dat_i[1:0];
      if (clr_err) begin
        txerr_q <= 1'b0;
        rxerr_q <= 1'b0;
      end else begin
        if (tx_ovf) txerr_q <= 1'b1;
        if (rx_udf) rxerr_q <= 1'b1;
      end
    end
  end

  // FIFO pointers; flush overrides any same-cycle stream or bus transfer.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_wr <= '0;
      tx_rd <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
    end else if (flush) begin
      tx_wr <= '0;
      tx_rd <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + ptr_t'(1);
      if (tx_pop)  tx_rd <= tx_rd + ptr_t'(1);
      if (rx_push) rx_wr <= rx_wr + ptr_t'(1);
      if (rx_pop)  rx_rd <= rx_rd + ptr_t'(1);
    end
  end

  // FIFO storage; contents are don't-care until pointers cover them.
  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem[tx_wr[DEPTH_LOG2-1:0]] <= wb.wbs_dat_i;
    if (rx_push) rx_mem[rx_wr[DEPTH_LOG2-1:0]] <= rx_data_i;
  end

  // Level interrupt sampled from current state, so it lags a change by one cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) irq_q <= 1'b0;
    else          irq_q <= (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty);
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_err_o = err_q;
  assign wb.wbs_dat_o = dat_q;
  assign wb.wbs_rty_o = 1'b0;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_wb_byte_fifo_port.sv
// Directed bench for wb_byte_fifo_port: bus reads checked against a response
// scoreboard, TX stream against a queue of written bytes, RX reads against a
// queue of streamed-in bytes.
module tb_wb_byte_fifo_port;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] dat;
    logic       err;
  } resp_t;

  resp_t      sb[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  wb_byte_fifo_port_if bus ();

  wb_byte_fifo_port #(.DEPTH_LOG2(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (bus.slave),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One classic beat; returns after sampling the response edge.
  task automatic wb_beat(input logic [1:0] a, input logic we, input logic [7:0] d,
                         output logic [7:0] rd, output logic got_err, output int lat);
    @(negedge clk);
    if (bus.wbs_ack_o || bus.wbs_err_o) @(negedge clk);
    bus.wbs_adr_i = {30'h0, a};
    bus.wbs_dat_i = d;
    bus.wbs_we_i  = we;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    lat = 0;
    got_err = 1'b0;
    rd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.wbs_ack_o || bus.wbs_err_o) break;
    end
    if (!(bus.wbs_ack_o || bus.wbs_err_o)) check("beat_timeout", 32'd0, 32'd1);
    check("ack_xor_err", 32'(bus.wbs_ack_o ^ bus.wbs_err_o), 32'd1);
    got_err = bus.wbs_err_o;
    rd = bus.wbs_dat_o;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input string tag, input logic [1:0] a, input logic [7:0] d, input logic exp_err);
    logic [7:0] rd;
    logic e;
    int lat;
    wb_beat(a, 1'b1, d, rd, e, lat);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
    check({tag, "_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic wb_read(input string tag, input logic [1:0] a, input logic [7:0] exp_dat, input logic exp_err);
    logic [7:0] rd;
    logic e;
    int lat;
    resp_t r;
    sb.push_back('{dat: exp_dat, err: exp_err});
    wb_beat(a, 1'b0, 8'h00, rd, e, lat);
    r = sb.pop_front();
    check({tag, "_dat"}, 32'(rd), 32'(r.dat));
    check({tag, "_err"}, 32'(e), 32'(r.err));
    check({tag, "_lat"}, 32'(lat), 32'd1);
  endtask

  // Data read whose expectation comes from the RX model.
  task automatic rx_read(input string tag);
    if (rx_q.size() == 0) wb_read(tag, 2'd0, 8'h00, 1'b1);
    else                  wb_read(tag, 2'd0, rx_q.pop_front(), 1'b0);
  endtask

  task automatic tx_write(input string tag, input logic [7:0] d);
    tx_q.push_back(d);
    wb_write(tag, 2'd0, d, 1'b0);
  endtask

  task automatic tx_drain(input string tag);
    @(negedge clk);
    tx_ready = 1'b1;
    while (tx_q.size() != 0) begin
      check({tag, "_valid"}, 32'(tx_valid), 32'd1);
      check({tag, "_data"}, 32'(tx_data), 32'(tx_q.pop_front()));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check({tag, "_empty"}, 32'(tx_valid), 32'd0);
  endtask

  task automatic rx_stream(input logic [7:0] d);
    @(negedge clk);
    rx_data  = d;
    rx_valid = 1'b1;
    if (rx_ready) rx_q.push_back(d);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 8'h00;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cti_i = 3'b000;
    bus.wbs_bte_i = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("rst_err", 32'(bus.wbs_err_o), 32'd0);
    check("rst_dat", 32'(bus.wbs_dat_o), 32'd0);
    check("rst_rty", 32'(bus.wbs_rty_o), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;

    // 1: status after reset
    wb_read("s1_status", 2'd1, 8'h05, 1'b0);
    check("s1_rx_ready", 32'(rx_ready), 32'd1);
    check("s1_irq", 32'(irq), 32'd0);

    // 2: two TX bytes, then drain
    tx_write("s2_w0", 8'hA5);
    tx_write("s2_w1", 8'h3C);
    #1;
    check("s2_valid", 32'(tx_valid), 32'd1);
    check("s2_head", 32'(tx_data), 32'hA5);
    tx_drain("s2_drain");

    // 3: fill TX, overflow, clear flags, drain
    for (int i = 0; i < 16; i++) tx_write("s3_fill", 8'(i * 7 + 1));
    wb_write("s3_ovf", 2'd0, 8'hEE, 1'b1);
    wb_read("s3_status_err", 2'd1, 8'h19, 1'b0);
    wb_write("s3_clear", 2'd3, 8'h00, 1'b0);
    wb_read("s3_status_clr", 2'd1, 8'h09, 1'b0);
    tx_drain("s3_drain");

    // 4: two RX bytes, then underflow
    rx_stream(8'h11);
    rx_stream(8'h22);
    wb_read("s4_level", 2'd3, 8'(rx_q.size()), 1'b0);
    rx_read("s4_rd0");
    rx_read("s4_rd1");
    rx_read("s4_udf");
    wb_read("s4_status", 2'd1, 8'h25, 1'b0);
    wb_write("s4_clear", 2'd3, 8'hFF, 1'b0);

    // 5: fill RX; pop while the stream is still offering a byte
    for (int i = 0; i < 16; i++) rx_stream(8'(8'h40 + i));
    check("s5_ready_full", 32'(rx_ready), 32'd0);
    wb_read("s5_status", 2'd1, 8'h06, 1'b0);
    @(negedge clk);
    rx_data  = 8'h99;
    rx_valid = 1'b1;
    rx_read("s5_pop");
    rx_valid = 1'b0;
    check("s5_ready_after", 32'(rx_ready), 32'd1);
    wb_read("s5_level", 2'd3, 8'(rx_q.size()), 1'b0);

    // 6: interrupt on RX data, then flush everything
    while (rx_q.size() > 3) rx_read("s6_drain");
    wb_read("s6_level", 2'd3, 8'd3, 1'b0);
    wb_write("s6_ctrl_en", 2'd2, 8'h01, 1'b0);
    for (int i = 0; i < 3 && irq !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    check("s6_irq_on", 32'(irq), 32'd1);
    wb_read("s6_ctrl_rd", 2'd2, 8'h01, 1'b0);
    tx_write("s6_tx0", 8'h5A);
    tx_write("s6_tx1", 8'h6B);
    wb_write("s6_flush", 2'd2, 8'h80, 1'b0);
    tx_q.delete();
    rx_q.delete();
    @(posedge clk);
    #1;
    check("s6_irq_off", 32'(irq), 32'd0);
    check("s6_tx_valid", 32'(tx_valid), 32'd0);
    wb_read("s6_status", 2'd1, 8'h05, 1'b0);
    wb_read("s6_ctrl_zero", 2'd2, 8'h00, 1'b0);
    wb_read("s6_level0", 2'd3, 8'h00, 1'b0);

    // CTRL bits 6:2 read zero; TX-empty interrupt; STATUS writes ignored
    wb_write("x_ctrl", 2'd2, 8'h7E, 1'b0);
    wb_read("x_ctrl_rd", 2'd2, 8'h02, 1'b0);
    @(posedge clk);
    #1;
    check("x_irq_tx", 32'(irq), 32'd1);
    wb_write("x_status_wr", 2'd1, 8'hFF, 1'b0);
    wb_read("x_status_rd", 2'd1, 8'h05, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
